// File: rtl/ptp_perout_ctrl.sv
// rtl/ptp_perout_ctrl.sv - configuration sequencer and lock supervisor for one ptp_perout
//
// Accepts one configuration request, then loads width, period and a start time
// that sits on a whole-second boundary LEAD_S seconds ahead of the sampled PTP
// time. It then waits for lock, re-arms on time steps and retries on timeout.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   input_ts_96         PTP time {s[47:0], 2'b00, ns[29:0], fns[15:0]}
//   input_ts_step       PTP time discontinuity strobe
//   cfg_period/width    96-bit period and high width, same format as input_ts_96
//   cfg_phase           {ns, fns} offset within the second
//   cfg_enable          output gate applied once the start time is loaded
//   cfg_valid/ready     request handshake
//   stop                abort to IDLE, highest priority
//   perout_*            load strobes/values and enable towards ptp_perout
//   perout_locked       lock indication from ptp_perout
//   busy, running       state != IDLE, state == RUN
//   cfg_error, fault    sticky status, cleared on the next accepted request
//   retry_count         re-arms in this session (timeouts + steps), saturating

module ptp_perout_ctrl #(
    parameter int FNS_ENABLE = 1,
    parameter int LEAD_S     = 2,
    parameter int TIMEOUT_S  = 3,
    parameter int MAX_RETRY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [95:0] input_ts_96,
    input  logic        input_ts_step,
    input  logic [95:0] cfg_period,
    input  logic [95:0] cfg_width,
    input  logic [45:0] cfg_phase,
    input  logic        cfg_enable,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        stop,
    output logic [95:0] perout_start,
    output logic        perout_start_valid,
    output logic [95:0] perout_period,
    output logic        perout_period_valid,
    output logic [95:0] perout_width,
    output logic        perout_width_valid,
    output logic        perout_enable,
    input  logic        perout_locked,
    output logic        busy,
    output logic        running,
    output logic        cfg_error,
    output logic        fault,
    output logic [3:0]  retry_count
);

    localparam logic [47:0] LEAD_W    = 48'(LEAD_S);
    localparam logic [47:0] TIMEOUT_W = 48'(TIMEOUT_S);
    localparam logic [3:0]  MAX_RETRY_W = 4'(MAX_RETRY);
    localparam logic [29:0] NS_LIMIT  = 30'd1_000_000_000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WIDTH,
        LOAD_PERIOD,
        CAPTURE,
        LOAD_START,
        WAIT_LOCK,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic [45:0] phase_q, phase_d;
    logic        en_q, en_d;
    logic [47:0] deadline_q, deadline_d;
    logic [3:0]  tmo_cnt_q, tmo_cnt_d;
    logic [3:0]  retry_count_q, retry_count_d;
    logic        cfg_ready_q, cfg_ready_d;
    logic        busy_q, busy_d;
    logic        running_q, running_d;
    logic        cfg_error_q, cfg_error_d;
    logic        fault_q, fault_d;
    logic        perout_enable_q, perout_enable_d;
    logic        start_valid_q, start_valid_d;
    logic        period_valid_q, period_valid_d;
    logic        width_valid_q, width_valid_d;
    logic [95:0] perout_start_q, perout_start_d;
    logic [95:0] perout_period_q, perout_period_d;
    logic [95:0] perout_width_q, perout_width_d;

    logic [47:0] ts_s;
    logic [47:0] start_s;
    logic        accept;
    logic        retry_inc;

    // Only the seconds field of the live time is ever compared or sampled.
    logic unused_ts_sub_s;
    assign unused_ts_sub_s = ^input_ts_96[47:0];

    assign ts_s = input_ts_96[95:48];

    function automatic logic [95:0] mask_fns(input logic [95:0] v);
        logic [95:0] r;
        r = v;
        if (FNS_ENABLE == 0) begin
            r[15:0] = 16'd0;
        end
        return r;
    endfunction

    // stop blocks acceptance in the same cycle even though cfg_ready is registered.
    assign accept = cfg_valid && cfg_ready_q && !stop;

    always_comb begin
        state_d         = state_q;
        phase_d         = phase_q;
        en_d            = en_q;
        deadline_d      = deadline_q;
        tmo_cnt_d       = tmo_cnt_q;
        retry_count_d   = retry_count_q;
        cfg_error_d     = cfg_error_q;
        fault_d         = fault_q;
        perout_start_d  = perout_start_q;
        perout_period_d = perout_period_q;
        perout_width_d  = perout_width_q;
        perout_enable_d = perout_enable_q;
        start_s         = ts_s + LEAD_W;
        retry_inc       = 1'b0;

        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        perout_period_d = mask_fns(cfg_period);
                        perout_width_d  = mask_fns(cfg_width);
                        phase_d         = cfg_phase;
                        en_d            = cfg_enable;
                        cfg_error_d     = 1'b0;
                        fault_d         = 1'b0;
                        retry_count_d   = 4'd0;
                        tmo_cnt_d       = 4'd0;
                        if (cfg_phase[45:16] >= NS_LIMIT) begin
                            cfg_error_d = 1'b1;
                        end else begin
                            state_d = LOAD_WIDTH;
                        end
                    end
                end
                LOAD_WIDTH: state_d = LOAD_PERIOD;
                LOAD_PERIOD: state_d = CAPTURE;
                CAPTURE: begin
                    perout_start_d = {start_s, 2'b00, phase_q[45:16],
                                      (FNS_ENABLE != 0) ? phase_q[15:0] : 16'd0};
                    deadline_d     = start_s + TIMEOUT_W;
                    state_d        = LOAD_START;
                end
                LOAD_START: begin
                    if (input_ts_step) begin
                        retry_inc = 1'b1;
                        state_d   = CAPTURE;
                    end else begin
                        state_d = WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    // A step outranks a simultaneous timeout and never counts
                    // towards the fault budget.
                    if (input_ts_step) begin
                        retry_inc = 1'b1;
                        state_d   = CAPTURE;
                    end else if (perout_locked) begin
                        state_d = RUN;
                    end else if (ts_s > deadline_q) begin
                        if (tmo_cnt_q < MAX_RETRY_W) begin
                            tmo_cnt_d = tmo_cnt_q + 4'd1;
                            retry_inc = 1'b1;
                            state_d   = CAPTURE;
                        end else begin
                            fault_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                RUN: begin
                    if (input_ts_step) begin
                        retry_inc = 1'b1;
                        state_d   = CAPTURE;
                    end else if (!perout_locked) begin
                        // Lock loss gets a fresh timeout window from now.
                        deadline_d = ts_s + TIMEOUT_W;
                        state_d    = WAIT_LOCK;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (retry_inc && (retry_count_q != 4'hF)) begin
            retry_count_d = retry_count_q + 4'd1;
        end

        // Enable follows the latched gate from the start load onwards and
        // drops whenever the sequencer returns to IDLE.
        if (state_d == IDLE) begin
            perout_enable_d = 1'b0;
        end else if (state_d == LOAD_START) begin
            perout_enable_d = en_q;
        end

        width_valid_d  = (state_d == LOAD_WIDTH);
        period_valid_d = (state_d == LOAD_PERIOD);
        start_valid_d  = (state_d == LOAD_START);
        cfg_ready_d    = (state_d == IDLE) && !stop;
        busy_d         = (state_d != IDLE);
        running_d      = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            phase_q         <= '0;
            en_q            <= 1'b0;
            deadline_q      <= '0;
            tmo_cnt_q       <= '0;
            retry_count_q   <= '0;
            cfg_ready_q     <= 1'b1;
            busy_q          <= 1'b0;
            running_q       <= 1'b0;
            cfg_error_q     <= 1'b0;
            fault_q         <= 1'b0;
            perout_enable_q <= 1'b0;
            start_valid_q   <= 1'b0;
            period_valid_q  <= 1'b0;
            width_valid_q   <= 1'b0;
            perout_start_q  <= '0;
            perout_period_q <= '0;
            perout_width_q  <= '0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            en_q            <= en_d;
            deadline_q      <= deadline_d;
            tmo_cnt_q       <= tmo_cnt_d;
            retry_count_q   <= retry_count_d;
            cfg_ready_q     <= cfg_ready_d;
            busy_q          <= busy_d;
            running_q       <= running_d;
            cfg_error_q     <= cfg_error_d;
            fault_q         <= fault_d;
            perout_enable_q <= perout_enable_d;
            start_valid_q   <= start_valid_d;
            period_valid_q  <= period_valid_d;
            width_valid_q   <= width_valid_d;
            perout_start_q  <= perout_start_d;
            perout_period_q <= perout_period_d;
            perout_width_q  <= perout_width_d;
        end
    end

    assign cfg_ready           = cfg_ready_q;
    assign busy                = busy_q;
    assign running             = running_q;
    assign cfg_error           = cfg_error_q;
    assign fault               = fault_q;
    assign retry_count         = retry_count_q;
    assign perout_enable       = perout_enable_q;
    assign perout_start        = perout_start_q;
    assign perout_start_valid  = start_valid_q;
    assign perout_period       = perout_period_q;
    assign perout_period_valid = period_valid_q;
    assign perout_width        = perout_width_q;
    assign perout_width_valid  = width_valid_q;

endmodule

// File: tb/tb_ptp_perout_ctrl.sv
// tb/tb_ptp_perout_ctrl.sv - scoreboard bench for ptp_perout_ctrl
module tb_ptp_perout_ctrl;

    localparam int LEAD_S    = 2;
    localparam int TIMEOUT_S = 3;
    localparam int MAX_RETRY = 2;
    localparam int KW = 0;
    localparam int KP = 1;
    localparam int KS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] input_ts_96;
    logic        input_ts_step;
    logic [95:0] cfg_period;
    logic [95:0] cfg_width;
    logic [45:0] cfg_phase;
    logic        cfg_enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        stop;
    logic [95:0] perout_start;
    logic        perout_start_valid;
    logic [95:0] perout_period;
    logic        perout_period_valid;
    logic [95:0] perout_width;
    logic        perout_width_valid;
    logic        perout_enable;
    logic        perout_locked;
    logic        busy;
    logic        running;
    logic        cfg_error;
    logic        fault;
    logic [3:0]  retry_count;

    typedef struct {
        int          kind;
        logic [95:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ptp_perout_ctrl #(
        .FNS_ENABLE(1),
        .LEAD_S(LEAD_S),
        .TIMEOUT_S(TIMEOUT_S),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .input_ts_96(input_ts_96),
        .input_ts_step(input_ts_step),
        .cfg_period(cfg_period),
        .cfg_width(cfg_width),
        .cfg_phase(cfg_phase),
        .cfg_enable(cfg_enable),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .stop(stop),
        .perout_start(perout_start),
        .perout_start_valid(perout_start_valid),
        .perout_period(perout_period),
        .perout_period_valid(perout_period_valid),
        .perout_width(perout_width),
        .perout_width_valid(perout_width_valid),
        .perout_enable(perout_enable),
        .perout_locked(perout_locked),
        .busy(busy),
        .running(running),
        .cfg_error(cfg_error),
        .fault(fault),
        .retry_count(retry_count)
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int kind, input logic [95:0] data);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe: kind %0d data %h, none expected", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data !== data) begin
                bad++;
                $display("FAIL strobe_kind%0d: got kind %0d data %h expected kind %0d data %h",
                         e.kind, kind, data, e.kind, e.data);
            end
        end
    endtask

    // Monitor: every strobe the DUT presents is matched against the queue.
    always @(negedge clk) begin
        if (perout_width_valid)  sb_pop(KW, perout_width);
        if (perout_period_valid) sb_pop(KP, perout_period);
        if (perout_start_valid)  sb_pop(KS, perout_start);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_time(input logic [47:0] s);
        input_ts_96 = {s, 2'b00, 30'($urandom_range(999_999_999, 0)), 16'($urandom)};
    endtask

    function automatic logic [45:0] rand_phase();
        return {30'($urandom_range(999_999_999, 0)), 16'($urandom)};
    endfunction

    // Reference: start lands LEAD_S whole seconds after the sampled second.
    function automatic logic [95:0] model_start(input logic [47:0] t, input logic [45:0] ph);
        return {t + 48'(LEAD_S), 2'b00, ph};
    endfunction

    function automatic logic [47:0] model_deadline(input logic [47:0] t);
        return t + 48'(LEAD_S) + 48'(TIMEOUT_S);
    endfunction

    task automatic push_exp(input int kind, input logic [95:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Issue one request at time t and advance to WAIT_LOCK.
    task automatic launch(input logic [47:0] t, input logic [45:0] ph, input logic en,
                          output logic [47:0] deadline);
        set_time(t);
        perout_locked = 1'b0;
        cfg_period = {48'd1, 2'b00, 30'($urandom_range(999_999_999, 0)), 16'($urandom)};
        cfg_width  = {48'd0, 2'b00, 30'($urandom_range(999_999_999, 1)), 16'($urandom)};
        cfg_phase  = ph;
        cfg_enable = en;
        push_exp(KW, cfg_width);
        push_exp(KP, cfg_period);
        push_exp(KS, model_start(t, ph));
        deadline = model_deadline(t);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick(4);
    endtask

    task automatic abort_session();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        perout_locked = 1'b0;
        chk("abort_busy", 96'(busy), 96'(0));
        chk("abort_enable", 96'(perout_enable), 96'(0));
        tick();
    endtask

    initial begin
        logic [47:0] dl;
        logic [47:0] t;
        logic [47:0] nt;
        logic [45:0] ph;
        logic        en;

        rst = 1'b1;
        input_ts_96 = '0;
        input_ts_step = 1'b0;
        cfg_period = '0;
        cfg_width = '0;
        cfg_phase = '0;
        cfg_enable = 1'b0;
        cfg_valid = 1'b0;
        stop = 1'b0;
        perout_locked = 1'b0;
        tick(3);
        rst = 1'b0;
        tick();

        chk("rst_cfg_ready", 96'(cfg_ready), 96'(1));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_running", 96'(running), 96'(0));
        chk("rst_enable", 96'(perout_enable), 96'(0));
        chk("rst_cfg_error", 96'(cfg_error), 96'(0));
        chk("rst_fault", 96'(fault), 96'(0));
        chk("rst_retry", 96'(retry_count), 96'(0));
        chk("rst_start", perout_start, 96'(0));
        chk("rst_period", perout_period, 96'(0));
        chk("rst_width", perout_width, 96'(0));

        // Basic bring-up with several times, phases and enables.
        for (int i = 0; i < 4; i++) begin
            t  = (i == 0) ? 48'd100 : 48'($urandom_range(1_000_000, 10));
            ph = (i == 0) ? 46'd0 : (i == 1) ? {30'd999_999_999, 16'($urandom)} : rand_phase();
            en = (i != 3);
            launch(t, ph, en, dl);
            chk("wait_busy", 96'(busy), 96'(1));
            chk("wait_running", 96'(running), 96'(0));
            chk("wait_enable", 96'(perout_enable), 96'(en));
            chk("wait_cfg_error", 96'(cfg_error), 96'(0));
            perout_locked = 1'b1;
            tick();
            chk("lock_running", 96'(running), 96'(1));
            abort_session();
        end

        // Phase ns out of range is rejected without strobes.
        for (int j = 0; j < 2; j++) begin
            cfg_phase = (j == 0) ? {30'd1_000_000_000, 16'd0}
                                 : {30'($urandom_range(1_073_741_823, 1_000_000_000)), 16'($urandom)};
            cfg_valid = 1'b1;
            tick();
            cfg_valid = 1'b0;
            chk("err_cfg_error", 96'(cfg_error), 96'(1));
            chk("err_cfg_ready", 96'(cfg_ready), 96'(1));
            chk("err_busy", 96'(busy), 96'(0));
            tick(3);
        end

        // Lock timeout with bounded retries, one step coinciding with a timeout.
        launch(48'd100, 46'd0, 1'b1, dl);
        chk("tmo_clears_cfg_error", 96'(cfg_error), 96'(0));
        set_time(dl);
        tick(2);
        chk("tmo_not_early", 96'(retry_count), 96'(0));
        for (int r = 0; r < MAX_RETRY; r++) begin
            nt = dl + 48'd1 + 48'($urandom_range(2, 0));
            set_time(nt);
            push_exp(KS, model_start(nt, 46'd0));
            dl = model_deadline(nt);
            tick(3);
            chk("tmo_retry", 96'(retry_count), 96'(r + 1));
            chk("tmo_no_fault", 96'(fault), 96'(0));
            chk("tmo_busy", 96'(busy), 96'(1));
        end
        nt = dl + 48'd1;
        set_time(nt);
        input_ts_step = 1'b1;
        push_exp(KS, model_start(nt, 46'd0));
        dl = model_deadline(nt);
        tick();
        input_ts_step = 1'b0;
        tick(2);
        chk("step_beats_tmo_fault", 96'(fault), 96'(0));
        chk("step_beats_tmo_retry", 96'(retry_count), 96'(MAX_RETRY + 1));
        set_time(dl + 48'd1);
        tick();
        chk("fault_set", 96'(fault), 96'(1));
        chk("fault_enable", 96'(perout_enable), 96'(0));
        chk("fault_busy", 96'(busy), 96'(0));
        chk("fault_retry", 96'(retry_count), 96'(MAX_RETRY + 1));
        chk("fault_cfg_ready", 96'(cfg_ready), 96'(1));
        tick();

        // Time step while running re-arms on the post-step second.
        launch(48'($urandom_range(400, 100)), rand_phase(), 1'b1, dl);
        chk("new_req_clears_fault", 96'(fault), 96'(0));
        perout_locked = 1'b1;
        tick();
        chk("step_pre_running", 96'(running), 96'(1));
        set_time(48'd500);
        input_ts_step = 1'b1;
        push_exp(KS, model_start(48'd500, cfg_phase));
        tick();
        input_ts_step = 1'b0;
        tick();
        chk("step_start_valid", 96'(perout_start_valid), 96'(1));
        tick();
        chk("step_retry", 96'(retry_count), 96'(1));
        chk("step_fault", 96'(fault), 96'(0));
        tick();
        chk("step_relock", 96'(running), 96'(1));
        // Lock loss opens a fresh window from the current second.
        perout_locked = 1'b0;
        tick();
        chk("unlock_running", 96'(running), 96'(0));
        chk("unlock_busy", 96'(busy), 96'(1));
        set_time(48'd500 + 48'(TIMEOUT_S));
        tick(2);
        chk("unlock_no_early_tmo", 96'(retry_count), 96'(1));
        nt = 48'd501 + 48'(TIMEOUT_S);
        set_time(nt);
        push_exp(KS, model_start(nt, cfg_phase));
        tick(3);
        chk("unlock_tmo_retry", 96'(retry_count), 96'(2));
        abort_session();

        // stop with a pending request holds it off until stop drops.
        t = 48'($urandom_range(9000, 1000));
        launch(t, rand_phase(), 1'b1, dl);
        ph = rand_phase();
        cfg_phase = ph;
        cfg_width = {48'd0, 2'b00, 30'($urandom_range(999_999_999, 1)), 16'($urandom)};
        stop = 1'b1;
        cfg_valid = 1'b1;
        tick();
        chk("stop_busy", 96'(busy), 96'(0));
        chk("stop_enable", 96'(perout_enable), 96'(0));
        chk("stop_cfg_ready", 96'(cfg_ready), 96'(0));
        tick();
        chk("stop_held_off", 96'(busy), 96'(0));
        stop = 1'b0;
        push_exp(KW, cfg_width);
        push_exp(KP, cfg_period);
        push_exp(KS, model_start(t, ph));
        tick();
        chk("stop_release_ready", 96'(cfg_ready), 96'(1));
        tick();
        cfg_valid = 1'b0;
        chk("stop_then_accept", 96'(busy), 96'(1));
        tick(4);
        chk("stop_req_wait", 96'(perout_enable), 96'(1));
        abort_session();

        // Reset while the period strobe is out: no start strobe follows.
        set_time(48'd777);
        cfg_phase = rand_phase();
        push_exp(KW, cfg_width);
        push_exp(KP, cfg_period);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_start_valid", 96'(perout_start_valid), 96'(0));
        chk("mrst_busy", 96'(busy), 96'(0));
        chk("mrst_cfg_ready", 96'(cfg_ready), 96'(1));
        chk("mrst_enable", 96'(perout_enable), 96'(0));
        chk("mrst_retry", 96'(retry_count), 96'(0));
        chk("mrst_start", perout_start, 96'(0));
        chk("mrst_width", perout_width, 96'(0));
        rst = 1'b0;
        tick(8);

        chk("sb_drained", 96'(exp_q.size()), 96'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
